// File: rtl/inv_revaluate_pkg.sv
// Shared constants, FSM encoding and row-extraction helper for the inverse chi block.
// The datapath option is selected in inv_revaluate.sv by INV_REVALUATE_PARALLEL_EN.
package inv_revaluate_pkg;

    localparam int ROW_W   = 5;
    localparam int STATE_W = 25;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Row r sits at s[24-5r:20-5r]; row 0 is the most significant slice.
    function automatic logic [ROW_W-1:0] get_row(input logic [STATE_W-1:0] s,
                                                 input logic [2:0]         r);
        case (r)
            3'd0:    get_row = s[24:20];
            3'd1:    get_row = s[19:15];
            3'd2:    get_row = s[14:10];
            3'd3:    get_row = s[9:5];
            default: get_row = s[4:0];
        endcase
    endfunction

endpackage

// File: rtl/inv_chi_row.sv
// Combinational inverse of the 5-bit chi row map a[x] ^ (~a[x+1] & a[x+2]).
// Column x lives at bit ROW_W-1-x, so column 0 is the MSB.
module inv_chi_row
    import inv_revaluate_pkg::*;
(
    input  logic [ROW_W-1:0] row_in,
    output logic [ROW_W-1:0] row_out
);

    for (genvar x = 0; x < ROW_W; x++) begin : g_col
        localparam int C0 = ROW_W - 1 - x;
        localparam int C1 = ROW_W - 1 - ((x + 1) % ROW_W);
        localparam int C2 = ROW_W - 1 - ((x + 2) % ROW_W);
        localparam int C3 = ROW_W - 1 - ((x + 3) % ROW_W);
        localparam int C4 = ROW_W - 1 - ((x + 4) % ROW_W);
        assign row_out[C0] = row_in[C0] ^
                             (~row_in[C1] & (row_in[C2] ^ (~row_in[C3] & row_in[C4])));
    end

endmodule

// File: rtl/inv_revaluate.sv
// Inverse chi over a 5x5-bit state: bit-serial by default (25 CALC cycles),
// one row per cycle (5 CALC cycles) when INV_REVALUATE_PARALLEL_EN is defined.
module inv_revaluate
    import inv_revaluate_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [STATE_W-1:0] in,
    output logic               ready,
    output logic               done,
    output logic [STATE_W-1:0] out,
    output logic [1:0]         dbg_state
);

    localparam logic [2:0] LAST = 3'd4;

    state_t             state_q, state_d;
    logic [STATE_W-1:0] in_q, in_d;
    logic [STATE_W-1:0] out_q, out_d;
    logic [2:0]         row_q, row_d;
    logic [ROW_W-1:0]   row_res;

    inv_chi_row u_row (
        .row_in  (get_row(in_q, row_q)),
        .row_out (row_res)
    );

`ifdef INV_REVALUATE_PARALLEL_EN
    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        out_d   = out_q;
        row_d   = row_q;
        case (state_q)
            IDLE: if (start) begin
                in_d    = in;
                out_d   = '0;
                row_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                out_d = {out_q[STATE_W-ROW_W-1:0], row_res};
                row_d = (row_q == LAST) ? 3'd0 : row_q + 3'd1;
                if (row_q == LAST) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            in_q    <= '0;
            out_q   <= '0;
            row_q   <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            out_q   <= out_d;
            row_q   <= row_d;
        end
    end
`else
    logic [2:0] col_q, col_d;
    logic       res_bit;

    // Column mux: column 0 (MSB) is emitted first within each row.
    always_comb begin
        case (col_q)
            3'd0:    res_bit = row_res[4];
            3'd1:    res_bit = row_res[3];
            3'd2:    res_bit = row_res[2];
            3'd3:    res_bit = row_res[1];
            default: res_bit = row_res[0];
        endcase
    end

    always_comb begin
        state_d = state_q;
        in_d    = in_q;
        out_d   = out_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            IDLE: if (start) begin
                in_d    = in;
                out_d   = '0;
                row_d   = '0;
                col_d   = '0;
                state_d = CALC;
            end
            CALC: begin
                out_d = {out_q[STATE_W-2:0], res_bit};
                col_d = (col_q == LAST) ? 3'd0 : col_q + 3'd1;
                if (col_q == LAST) begin
                    row_d = (row_q == LAST) ? 3'd0 : row_q + 3'd1;
                    if (row_q == LAST) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            in_q    <= '0;
            out_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            in_q    <= in_d;
            out_q   <= out_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end
`endif

    assign ready     = (state_q == IDLE);
    assign done      = (state_q == DONE);
    assign out       = out_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_inv_revaluate.sv
// Scoreboard bench for inv_revaluate: drivers push expected results and start cycles,
// a negedge monitor pops and compares on every done pulse (value and latency).
module tb_inv_revaluate;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [24:0] in_r = '0;
    logic        ready, done;
    logic [24:0] out;
    logic [1:0]  dbg_state;

`ifdef INV_REVALUATE_PARALLEL_EN
    localparam int LAT = 6;
`else
    localparam int LAT = 26;
`endif

    logic [24:0] exp_q[$];
    int          acc_q[$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    inv_revaluate dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in        (in_r),
        .ready     (ready),
        .done      (done),
        .out       (out),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [24:0] act, input logic [24:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Forward chi map, applied row by row (column 0 = row MSB).
    function automatic logic [24:0] chi_fwd(input logic [24:0] s);
        logic [24:0] r;
        logic [4:0]  a, b;
        r = '0;
        for (int row = 0; row < 5; row++) begin
            a = s[24-5*row -: 5];
            for (int x = 0; x < 5; x++)
                b[4-x] = a[4-x] ^ (~a[4-((x+1)%5)] & a[4-((x+2)%5)]);
            r[24-5*row -: 5] = b;
        end
        return r;
    endfunction

    // Monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rst && done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got out=%h with no pending operation", out);
            end else begin
                logic [24:0] e;
                int          a;
                e = exp_q.pop_front();
                a = acc_q.pop_front();
                check("result", out, e);
                check("latency", 25'(cyc - a), 25'(LAT));
                check("ready_low_in_done", {24'b0, ready}, 25'd0);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || !ready) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout: got ready=%b pending=%0d expected idle", ready, exp_q.size());
            exp_q.delete();
            acc_q.delete();
        end
    endtask

    task automatic run_op(input logic [24:0] v, input logic [24:0] e);
        wait_idle();
        start = 1'b1;
        in_r  = v;
        exp_q.push_back(e);
        acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;
        in_r  = $urandom;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        errors++;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] s;
        int          n;
        logic        saw_done;

        // Reset held for two edges.
        repeat (2) @(negedge clk);
        check("rst_ready", {24'b0, ready}, 25'd1);
        check("rst_done", {24'b0, done}, 25'd0);
        check("rst_out", out, 25'h0);
        rst = 1'b1;

        // Directed vectors.
        run_op(25'h1200000, 25'h1000000);
        run_op({5{5'b11010}}, {5{5'b11000}});
        run_op(25'h1FFFFFF, 25'h1FFFFFF);
        run_op(25'h0000000, 25'h0000000);

        // Start held high, in scrambled during CALC, then back-to-back acceptance.
        wait_idle();
        start = 1'b1;
        in_r  = {5{5'b11010}};
        exp_q.push_back({5{5'b11000}});
        acc_q.push_back(cyc);
        n = 0;
        @(negedge clk);
        while (!done && n < 60) begin
            in_r = $urandom;
            @(negedge clk);
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL held_start_timeout: got done=%b expected 1", done);
        end
        in_r = 25'h1200000;
        @(negedge clk);
        check("b2b_ready_after_done", {24'b0, ready}, 25'd1);
        exp_q.push_back(25'h1000000);
        acc_q.push_back(cyc);
        @(negedge clk);
        start = 1'b0;

        // Reset during CALC: no done pulse, block returns to IDLE cleared.
        wait_idle();
        start = 1'b1;
        in_r  = 25'h1FFFFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        check("midrst_ready", {24'b0, ready}, 25'd1);
        check("midrst_out", out, 25'h0);
        check("midrst_done", {24'b0, done}, 25'd0);
        saw_done = 1'b0;
        repeat (30) begin
            @(negedge clk);
            saw_done |= done;
        end
        check("midrst_no_done", {24'b0, saw_done}, 25'd0);
        run_op({5{5'b11010}}, {5{5'b11000}});

        // Round trip: forward chi of a random state must invert back to it.
        for (int i = 0; i < 1000; i++) begin
            s = 25'($urandom);
            run_op(chi_fwd(s), s);
        end

        wait_idle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
